// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC and drives the imem req/ack handshake into IF/ID.
// Latency: imem_ack in cycle N gives ir/ir_valid in cycle N+1; zero-wait memory sustains 1 instr/cycle.
// Backpressure: stall holds the outputs and the PC. A word that arrives during a stall is parked in a one-entry skid buffer.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_plus4,
    output logic        ir_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ir_n, pc_plus4_n;
    logic        ir_valid_n;
    logic [31:0] skid_q, skid_n;
    logic [31:0] redirect, redirect_n;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target    = {branch_target[31:2], 2'b00};
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;
    // The HOLD state already owns a word, so no new request is issued there.
    assign imem_req  = !reset && (state != HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= {RESET_PC[31:2], 2'b00};
            ir       <= 32'h0000_0000;
            pc_plus4 <= 32'h0000_0000;
            ir_valid <= 1'b0;
            skid_q   <= 32'h0000_0000;
            redirect <= 32'h0000_0000;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            pc_plus4 <= pc_plus4_n;
            ir_valid <= ir_valid_n;
            skid_q   <= skid_n;
            redirect <= redirect_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        pc_plus4_n = pc_plus4;
        ir_valid_n = ir_valid;
        skid_n     = skid_q;
        redirect_n = redirect;
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    ir_n       = 32'h0000_0000;
                    ir_valid_n = 1'b0;
                    if (imem_ack) begin
                        pc_n = target;
                    end else begin
                        // The outstanding request must complete before the PC may move.
                        redirect_n = target;
                        state_n    = DRAIN;
                    end
                end else if (imem_ack && !stall) begin
                    ir_n       = imem_rdata;
                    pc_plus4_n = pc_inc;
                    ir_valid_n = 1'b1;
                    pc_n       = pc_inc;
                end else if (imem_ack) begin
                    skid_n  = imem_rdata;
                    state_n = HOLD;
                end else if (!stall) begin
                    ir_n       = 32'h0000_0000;
                    ir_valid_n = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_n       = target;
                    ir_n       = 32'h0000_0000;
                    ir_valid_n = 1'b0;
                    state_n    = FETCH;
                end else if (!stall) begin
                    ir_n       = skid_q;
                    pc_plus4_n = pc_inc;
                    ir_valid_n = 1'b1;
                    pc_n       = pc_inc;
                    state_n    = FETCH;
                end
            end
            DRAIN: begin
                ir_n       = 32'h0000_0000;
                ir_valid_n = 1'b0;
                if (branch_taken) begin
                    redirect_n = target;
                end
                if (imem_ack) begin
                    pc_n    = branch_taken ? target : redirect;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Presents the fetched 32-bit instruction and PC+4 to the IF/ID pipeline register, which splits the instruction into fields.
- Honours stall from the hazard unit and redirect from branch/jump resolution, and inserts NOP bubbles when memory is slow.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hazard unit: hold IF outputs and PC this cycle.
branch_taken  input  1  redirect request; takes priority over stall.
branch_target  input  32  new PC when branch_taken=1.
imem_req  output  1  instruction memory request.
imem_addr  output  32  word-aligned fetch address; equals PC.
imem_ack  input  1  memory has valid imem_rdata this cycle; may be asserted in the same cycle as imem_req.
imem_rdata  input  32  instruction word, sampled only when imem_req && imem_ack.
ir  output  32  instruction to IF/ID; 32'h0000_0000 (NOP) when invalid.
pc_plus4  output  32  address of ir + 4.
ir_valid  output  1  ir holds a real instruction.

Behaviour:
- Reset (synchronous, when reset=1 at posedge):
  - pc=RESET_PC, ir=0, pc_plus4=0, ir_valid=0.
  - Skid buffer cleared; state=FETCH.
  - imem_req=0 during any cycle with reset high.
- Handshake rules:
  - Once imem_req=1, imem_addr is held stable until the cycle in which imem_ack=1.
  - imem_addr is a direct copy of pc; pc[1:0] are always 00. A branch_target with bits [1:0] nonzero is forced to 00.
  - PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- State FETCH (imem_req=1):
  - branch_taken && imem_ack: rdata discarded; pc<=branch_target; ir<=0; ir_valid<=0; stay FETCH. imem_req stays 1 with the new address next cycle.
  - branch_taken && !imem_ack: save branch_target into redirect register; ir<=0; ir_valid<=0; go to DRAIN.
  - imem_ack && !stall: ir<=imem_rdata; pc_plus4<=pc+4; ir_valid<=1; pc<=pc+4.
  - imem_ack && stall: buf<=imem_rdata; IF outputs held; go to HOLD.
  - !imem_ack && !stall: bubble, ir<=0, ir_valid<=0.
  - !imem_ack && stall: outputs held.
- State HOLD (imem_req=0; pc = address of the buffered instruction):
  - branch_taken: buffer discarded; pc<=branch_target; ir<=0; ir_valid<=0; go to FETCH.
  - !stall: ir<=buf; pc_plus4<=pc+4; ir_valid<=1; pc<=pc+4; go to FETCH.
  - stall: hold everything.
- State DRAIN (imem_req=1, imem_addr = old pc, held stable):
  - A further branch_taken overwrites the redirect register (latest wins).
  - On imem_ack: rdata discarded; pc<=redirect (or branch_target if branch_taken in the same cycle); go to FETCH.
  - ir stays 0 and ir_valid stays 0 throughout; stall has no effect in DRAIN.
- Latency and throughput:
  - imem_ack in cycle N makes ir/ir_valid visible in cycle N+1.
  - With a zero-wait memory (ack in the same cycle as req), sustained throughput is 1 instruction/cycle with no bubbles.
  - First valid ir appears 2 cycles after reset deasserts.
- Simultaneous events:
  - branch_taken overrides stall in all states.
  - reset overrides everything, including an outstanding request. Memory must tolerate an abandoned request.
- Bubbles:
  - ir_valid=0 always coincides with ir=0, so downstream decode sees sll $0,$0,0.

Test Plan:
- Reset, zero-wait memory returning word=addr, RESET_PC=0 → ir sequence 0x0, 0x4, 0x8 on consecutive cycles from cycle 2; pc_plus4 = 4, 8, 12; ir_valid=1 continuously.
- Memory acks every 3rd cycle → ir_valid pattern 0,0,1 repeating; ir=0 in bubble cycles; imem_addr stable while unacked.
- stall=1 for 3 cycles coincident with ack of addr 0x10 (word 0xAAAA_0010) → FSM enters HOLD, imem_req=0. After release: ir=0xAAAA_0010, pc_plus4=0x14; next fetch address 0x14.
- branch_taken with target 0x100 while a request to 0x20 is unacked for 2 more cycles → DRAIN holds imem_addr=0x20 until ack; word discarded; next imem_addr=0x100. ir_valid=0 until the 0x100 instruction arrives.
- branch_taken and stall asserted together in HOLD, target 0x40 → buffer discarded, pc=0x40, ir_valid=0 next cycle.
- PC wrap: RESET_PC=0xFFFF_FFFC, zero-wait memory → first ir from 0xFFFF_FFFC with pc_plus4=0; next imem_addr=0x0. Assert reset mid-DRAIN → all outputs return to reset values at the next posedge.
